// File: rtl/ad_uart_pkg.sv
// Shared types and constants for the ADC-sample UART transmitter.
package ad_uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Number of bytes in a formatted message: three digits plus CR LF.
    localparam logic [2:0] MSG_LEN = 3'd5;

    // Bit period in clock cycles, integer-truncated.
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Byte idx of the formatted message "hto\r\n".
    function automatic logic [7:0] msg_byte(input logic [2:0] idx,
                                            input logic [3:0] h,
                                            input logic [3:0] t,
                                            input logic [3:0] o);
        case (idx)
            3'd0:    return ASCII_0 + {4'h0, h};
            3'd1:    return ASCII_0 + {4'h0, t};
            3'd2:    return ASCII_0 + {4'h0, o};
            3'd3:    return ASCII_CR;
            3'd4:    return ASCII_LF;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ad_uart_tx_if.sv
// Sample input and serial output bundle of ad_uart_tx.
interface ad_uart_tx_if;
    logic [7:0] ad_data;
    logic       ad_done;
    logic       uart_tx;
    logic       busy;
    logic       drop;

    modport master (output ad_data, ad_done, input uart_tx, busy, drop);
    modport slave  (input ad_data, ad_done, output uart_tx, busy, drop);
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter. done pulses in the last stop-bit cycle; a start
// in that same cycle chains the next byte with no idle gap.
module uart_byte_tx #(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic             active_q, active_d;
    logic             tx_q, tx_d;
    logic [7:0]       shift_q, shift_d;
    logic [3:0]       bit_q, bit_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic             bit_end;
    logic             last_bit;

    // bit_q: 0 = start bit, 1..8 = data bits, 9 = stop bit.
    assign bit_end  = active_q && (baud_q == CNT_W'(BAUD_DIV - 1));
    assign last_bit = (bit_q == 4'd9);
    assign done     = bit_end && last_bit;
    assign tx       = tx_q;

    // Advance baud/bit counters and shift the next line level out.
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        active_d = active_q;
        tx_d     = tx_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        baud_d   = baud_q;
        if (active_q) begin
            if (bit_end) begin
                baud_d = '0;
                if (last_bit) begin
                    active_d = 1'b0;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[7:1]};
                end
            end else begin
                baud_d = baud_q + CNT_W'(1);
            end
        end
        if (start && (!active_q || done)) begin
            active_d = 1'b1;
            tx_d     = 1'b0;
            shift_d  = data;
            bit_d    = 4'd0;
            baud_d   = '0;
        end
    end

    // Transmitter state register with synchronous reset to an idle-high line.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            tx_q     <= 1'b1;
            shift_q  <= '0;
            bit_q    <= '0;
            baud_q   <= '0;
        end else begin
            active_q <= active_d;
            tx_q     <= tx_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
        end
    end

endmodule

// File: rtl/ad_uart_tx.sv
// Sends each accepted ADC sample over an 8N1 UART line.
// Macro AD_UART_ASCII_EN: send "hto\r\n" decimal text instead of the raw byte.
module ad_uart_tx
    import ad_uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input logic         clk,
    input logic         rst_n,
    ad_uart_tx_if.slave bus
);
    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);

    state_e     state_q, state_d;
    logic       busy_q, busy_d;
    logic       drop_q, drop_d;
    logic       accept;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       tx_line;
`ifdef AD_UART_ASCII_EN
    logic [7:0] rem_q, rem_d;
    logic [3:0] hund_q, hund_d;
    logic [3:0] tens_q, tens_d;
    logic [2:0] idx_q, idx_d;
`endif

    assign accept = bus.ad_done && (state_q == IDLE) && !busy_q;

    // Message sequencing: accept, convert to digits, feed bytes to the transmitter.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        drop_d   = bus.ad_done && !accept;
        tx_start = 1'b0;
        tx_data  = 8'h00;
`ifdef AD_UART_ASCII_EN
        rem_d    = rem_q;
        hund_d   = hund_q;
        tens_d   = tens_q;
        idx_d    = idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    busy_d = 1'b1;
`ifdef AD_UART_ASCII_EN
                    rem_d   = bus.ad_data;
                    hund_d  = 4'd0;
                    tens_d  = 4'd0;
                    state_d = CONV;
`else
                    tx_start = 1'b1;
                    tx_data  = bus.ad_data;
                    state_d  = SEND;
`endif
                end
            end
`ifdef AD_UART_ASCII_EN
            CONV: begin
                if (rem_q >= 8'd100) begin
                    rem_d  = rem_q - 8'd100;
                    hund_d = hund_q + 4'd1;
                end else if (rem_q >= 8'd10) begin
                    rem_d  = rem_q - 8'd10;
                    tens_d = tens_q + 4'd1;
                end else begin
                    // Digits are final: launch the first byte this cycle.
                    tx_start = 1'b1;
                    tx_data  = msg_byte(3'd0, hund_q, tens_q, rem_q[3:0]);
                    idx_d    = 3'd1;
                    state_d  = SEND;
                end
            end
`endif
            SEND: begin
                if (tx_done) begin
`ifdef AD_UART_ASCII_EN
                    if (idx_q == MSG_LEN) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        tx_start = 1'b1;
                        tx_data  = msg_byte(idx_q, hund_q, tens_q, rem_q[3:0]);
                        idx_d    = idx_q + 3'd1;
                    end
`else
                    state_d = IDLE;
                    busy_d  = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
`ifdef AD_UART_ASCII_EN
            rem_q   <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
`ifdef AD_UART_ASCII_EN
            rem_q   <= rem_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            idx_q   <= idx_d;
`endif
        end
    end

    uart_byte_tx #(.BAUD_DIV(BAUD_DIV)) u_byte_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tx_start),
        .data  (tx_data),
        .tx    (tx_line),
        .done  (tx_done)
    );

    assign bus.uart_tx = tx_line;
    assign bus.busy    = busy_q;
    assign bus.drop    = drop_q;

endmodule

// File: tb/tb_ad_uart_tx.sv
// Self-checking bench for ad_uart_tx; follows AD_UART_ASCII_EN like the RTL.
module tb_ad_uart_tx;
`ifdef AD_UART_ASCII_EN
    localparam int CLK_FREQ = 1_000_050;
    localparam int BAUD     = 10_000;
    localparam int DIV      = 100;
`else
    localparam int CLK_FREQ = 1_000_100;
    localparam int BAUD     = 2500;
    localparam int DIV      = 400;
`endif

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;
    int   free_cyc;
    int   first_start;
    bit   mon_abort;
    exp_t exp_q[$];

    ad_uart_tx_if bus ();

    ad_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cyc > 95000) begin
            $display("FAIL watchdog: cycle %0d exceeded budget 95000", cyc);
            $fatal(1, "watchdog");
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    // Drive one ad_done strobe and check the drop/busy response a cycle later.
    task automatic strobe(input logic [7:0] v);
        int   c;
        int   s;
        logic acc;
        c   = cyc;
        acc = (c >= free_cyc);
        bus.ad_data = v;
        bus.ad_done = 1'b1;
        if (acc) begin
`ifdef AD_UART_ASCII_EN
            int h;
            int t;
            int o;
            h = v / 100;
            t = (v % 100) / 10;
            o = v % 10;
            s = c + 2 + h + t;
            exp_q.push_back('{8'h30 + 8'(h), s});
            exp_q.push_back('{8'h30 + 8'(t), s + 10 * DIV});
            exp_q.push_back('{8'h30 + 8'(o), s + 20 * DIV});
            exp_q.push_back('{8'h0D, s + 30 * DIV});
            exp_q.push_back('{8'h0A, s + 40 * DIV});
            free_cyc = s + 50 * DIV;
`else
            s = c + 1;
            exp_q.push_back('{v, s});
            free_cyc = s + 10 * DIV;
`endif
            first_start = s;
        end
        tick();
        bus.ad_done = 1'b0;
        check("drop", bus.drop, !acc);
        check("busy", bus.busy, cyc < free_cyc);
    endtask

    // Run to the end of the current message and check the busy fall edge.
    task automatic wait_free();
        wait_until(free_cyc - 1);
        check("busy_hold", bus.busy, 1'b1);
        tick();
        check("busy_fall", bus.busy, 1'b0);
        check("line_idle", bus.uart_tx, 1'b1);
    endtask

    // Line monitor: checks every cycle of each frame against the scoreboard.
    initial begin
        exp_t       e;
        int         t0;
        int         errs;
        int         b;
        logic       eb;
        logic [7:0] got;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.uart_tx === 1'b0) begin
                t0      = cyc;
                errs    = 0;
                got     = 8'h00;
                aborted = 1'b0;
                check("sb_has_entry", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) e = exp_q.pop_front();
                else e = '{8'h00, -1};
                for (int n = 0; n < 10 * DIV; n++) begin
                    if (n > 0) @(negedge clk);
                    if (mon_abort) begin
                        mon_abort = 1'b0;
                        aborted   = 1'b1;
                        break;
                    end
                    b  = n / DIV;
                    eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
                    if (bus.uart_tx !== eb) errs++;
                    if ((n % DIV) == DIV / 2 && b >= 1 && b <= 8) got[b-1] = bus.uart_tx;
                end
                if (!aborted) begin
                    check("start_cyc", t0, e.cyc);
                    check("frame_bits", errs, 0);
                    check("byte", got, e.data);
                end
            end
        end
    end

    initial begin
        logic [7:0] samples [4];
        int         k;
        bit         was_busy;
        samples = '{8'hA5, 8'h00, 8'h09, 8'hFF};
        tests = 0;
        fails = 0;
        free_cyc = 0;
        mon_abort = 1'b0;
        rst_n = 1'b0;
        bus.ad_data = 8'h00;
        bus.ad_done = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_tx", bus.uart_tx, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_drop", bus.drop, 1'b0);
        rst_n = 1'b1;
        tick();
        free_cyc = cyc;

        // Single messages with distinct values.
        foreach (samples[i]) begin
            strobe(samples[i]);
            wait_free();
            tick();
        end

        // Strobes every 1300 cycles while busy are dropped; first one after is taken.
        strobe(8'h5C);
        k = cyc - 1;
        for (int i = 1; i <= 8; i++) begin
            wait_until(k + 1300 * i);
            was_busy = (cyc < free_cyc);
            strobe(8'h10 + 8'(i));
            if (!was_busy) break;
        end
        wait_free();

        // Consecutive rejected strobes give consecutive drop pulses.
        strobe(8'h3C);
        strobe(8'h22);
        strobe(8'h33);
        tick();
        check("drop_clear", bus.drop, 1'b0);
        wait_free();

        // Reset during the 3rd data bit abandons the frame.
        strobe(8'hC3);
        wait_until(first_start + 3 * DIV + 5);
        mon_abort = 1'b1;
        rst_n = 1'b0;
        tick();
        check("midrst_tx", bus.uart_tx, 1'b1);
        check("midrst_busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        exp_q.delete();
        free_cyc = cyc;
        tick();
        check("post_rst_tx", bus.uart_tx, 1'b1);
        strobe(8'h96);
        wait_free();

        // ad_done in the last stop-bit cycle is dropped; one cycle later is taken.
        strobe(8'h81);
        wait_until(free_cyc - 1);
        strobe(8'h42);
        strobe(8'h7E);
        wait_free();

        tick();
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
